// File: rtl/packet_stream_arbiter.sv
// packet_stream_arbiter
//
// Packet-atomic round-robin arbiter that merges NUM_SRC packet sources onto one
// registered sink with no backpressure. In idle, a source presenting a valid
// start-of-packet word is a request. The first requester at or after rr_ptr
// wins and owns the output until its end-of-packet word is accepted.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   in_valid/in_sop/in_eop     per-source word qualifiers (NUM_SRC bits)
//   in_data/in_byte_enable     per-source payload, source i at [i*W +: W]
//   in_ready          per-source accept; only the granted source in STREAM
//   out_valid/out_data/out_byte_enable/out_sop/out_eop
//                     registered copy of the accepted word (latency 1)
//   grant_idx         index of the owning source (meaningful while busy)
//   busy              1 while a packet is being streamed
//   protocol_err      one-cycle pulse on a framing error in an accepted word
//   pkt_count         per-source accepted-eop counters, 32 bits each
//                     (only when PKT_ARB_PKT_COUNT_EN is defined)
//
// Optional feature macro: PKT_ARB_PKT_COUNT_EN
module packet_stream_arbiter #(
    parameter int unsigned  NUM_SRC = 4,
    parameter int unsigned  DATA_W  = 64,
    parameter int unsigned  BE_W    = 8,
    localparam int unsigned IDX_W   = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        in_valid,
    input  logic [NUM_SRC*DATA_W-1:0] in_data,
    input  logic [NUM_SRC*BE_W-1:0]   in_byte_enable,
    input  logic [NUM_SRC-1:0]        in_sop,
    input  logic [NUM_SRC-1:0]        in_eop,
    output logic [NUM_SRC-1:0]        in_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [BE_W-1:0]           out_byte_enable,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic [IDX_W-1:0]          grant_idx,
    output logic                      busy,
`ifdef PKT_ARB_PKT_COUNT_EN
    output logic [NUM_SRC*32-1:0]     pkt_count,
`endif
    output logic                      protocol_err
);

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]    rr_q, rr_d;
    // Set on grant; the next accepted word is the first of the packet.
    logic                first_q, first_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [BE_W-1:0]     out_be_q, out_be_d;
    logic                out_sop_q, out_sop_d;
    logic                out_eop_q, out_eop_d;
    logic                perr_q, perr_d;

    logic [NUM_SRC-1:0]  req;
    logic                found;
    logic [IDX_W-1:0]    pick;
    int unsigned         cand;
    logic                accept;
    logic                sop_g;
    logic                eop_g;

    assign req    = in_valid & in_sop;
    assign accept = (state_q == StStream) && in_valid[grant_q];
    assign sop_g  = in_sop[grant_q];
    assign eop_g  = in_eop[grant_q];

    // Round-robin scan starting at rr_ptr.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = 0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            cand = int'(rr_q) + k;
            if (cand >= NUM_SRC) begin
                cand = cand - NUM_SRC;
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        first_d     = first_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_be_d    = out_be_q;
        out_sop_d   = 1'b0;
        out_eop_d   = 1'b0;
        perr_d      = 1'b0;
        in_ready    = '0;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d = pick;
                    first_d = 1'b1;
                    state_d = StStream;
                end
            end
            StStream: begin
                // Ready depends only on ownership, never on in_valid.
                in_ready[grant_q] = 1'b1;
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_data_d  = in_data[grant_q*DATA_W +: DATA_W];
                    out_be_d    = in_byte_enable[grant_q*BE_W +: BE_W];
                    out_sop_d   = sop_g;
                    out_eop_d   = eop_g;
                    perr_d      = first_q ? !sop_g : sop_g;
                    first_d     = 1'b0;
                    if (eop_g) begin
                        state_d = StIdle;
                        rr_d    = (grant_q == IDX_W'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            rr_q        <= '0;
            first_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_be_q    <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            first_q     <= first_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_be_q    <= out_be_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            perr_q      <= perr_d;
        end
    end

`ifdef PKT_ARB_PKT_COUNT_EN
    logic [NUM_SRC*32-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (accept && eop_g) begin
            cnt_d[grant_q*32 +: 32] = cnt_q[grant_q*32 +: 32] + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pkt_count = cnt_q;
`endif

    assign out_valid       = out_valid_q;
    assign out_data        = out_data_q;
    assign out_byte_enable = out_be_q;
    assign out_sop         = out_sop_q;
    assign out_eop         = out_eop_q;
    assign grant_idx       = grant_q;
    assign busy            = (state_q == StStream);
    assign protocol_err    = perr_q;

endmodule
